// File: rtl/width_conv_pkg.sv
// Shared helpers for the width converters: lane mapping, counter sizing and
// parameter legality, used by the upsizer and the planned downsizer.
package width_conv_pkg;

  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Beat k of a word lands in lane RATIO-1-k when filling from the MSB end.
  function automatic int lane_index(input int cnt, input bit msb_first, input int ratio);
    if (msb_first) begin
      return ratio - 1 - cnt;
    end else begin
      return cnt;
    end
  endfunction

  function automatic bit params_legal(input int in_w, input int ratio);
    return (in_w >= 1) && (ratio >= 1);
  endfunction

endpackage

// File: rtl/width_conv_out_reg.sv
// Valid/ready holding register for one output word with per-lane keep and last.
// The word stays stable until the consumer takes it.
module width_conv_out_reg #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic              ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last
);

  // Free to load when empty or when the current word leaves this cycle.
  assign ready = !out_valid || out_ready;

  // Output word register; a load overrides the drain so words go back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/width_upsizer.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_W bits into one word,
// with early close on in_last and per-lane keep.
module width_upsizer
  import width_conv_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_last
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = cnt_width(RATIO);

  if (!params_legal(IN_W, RATIO)) begin : g_param_check
    $error("width_upsizer: IN_W and RATIO must both be >= 1");
  end

  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] acc_keep;
  logic [CNT_W-1:0] cnt;

  int               lane;
  logic [OUT_W-1:0] beat_data;
  logic [RATIO-1:0] beat_keep;
  logic             completing;
  logic             accept;

  assign accept = in_valid && in_ready;

  // Merge the current beat into the accumulator at the lane picked by cnt.
  always_comb begin
    lane       = lane_index(int'(cnt), MSB_FIRST, RATIO);
    beat_data  = acc | (OUT_W'(in_data) << (lane * IN_W));
    beat_keep  = acc_keep | (RATIO'(1'b1) << lane);
    completing = (cnt == CNT_W'(RATIO - 1)) || in_last;
  end

  // Accumulator and lane counter; cleared whenever a word is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_keep <= '0;
      cnt      <= '0;
    end else if (accept && completing) begin
      acc      <= '0;
      acc_keep <= '0;
      cnt      <= '0;
    end else if (accept) begin
      acc      <= beat_data;
      acc_keep <= beat_keep;
      cnt      <= cnt + CNT_W'(1);
    end else begin
      acc      <= acc;
      acc_keep <= acc_keep;
      cnt      <= cnt;
    end
  end

  width_conv_out_reg #(
    .DATA_W(OUT_W),
    .KEEP_W(RATIO)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && completing),
    .load_data(beat_data),
    .load_keep(beat_keep),
    .load_last(in_last),
    .ready    (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_width_upsizer.sv
// Directed bench for width_upsizer with three configurations side by side:
// 8x2 MSB-first, 8x4 MSB-first, 8x4 LSB-first.
module tb_width_upsizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // 8x2, MSB first
  logic        a_iv = 1'b0, a_il = 1'b0, a_or = 1'b1;
  logic [7:0]  a_id = '0;
  logic        a_ir, a_ov, a_ol;
  logic [15:0] a_od;
  logic [1:0]  a_ok;
  // 8x4, MSB first
  logic        b_iv = 1'b0, b_il = 1'b0, b_or = 1'b1;
  logic [7:0]  b_id = '0;
  logic        b_ir, b_ov, b_ol;
  logic [31:0] b_od;
  logic [3:0]  b_ok;
  // 8x4, LSB first
  logic        c_iv = 1'b0, c_il = 1'b0, c_or = 1'b1;
  logic [7:0]  c_id = '0;
  logic        c_ir, c_ov, c_ol;
  logic [31:0] c_od;
  logic [3:0]  c_ok;

  width_upsizer #(.IN_W(8), .RATIO(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_last(a_il),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_keep(a_ok), .out_last(a_ol));
  width_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_last(b_il),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_keep(b_ok), .out_last(b_ol));
  width_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_last(c_il),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_keep(c_ok), .out_last(c_ol));

  int a_words = 0;
  always @(posedge clk) if (a_ov && a_or) a_words <= a_words + 1;

  task automatic send_a(input logic [7:0] d, input logic l);
    a_iv = 1'b1; a_id = d; a_il = l;
    @(posedge clk); #1;
    a_iv = 1'b0; a_il = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    b_iv = 1'b1; b_id = d; b_il = l;
    @(posedge clk); #1;
    b_iv = 1'b0; b_il = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] d, input logic l);
    c_iv = 1'b1; c_id = d; c_il = l;
    @(posedge clk); #1;
    c_iv = 1'b0; c_il = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(a_ov), 32'd0);
    check("rst_data",  32'(b_od), 32'd0);
    check("rst_keep",  32'(b_ok), 32'd0);
    check("rst_last",  32'(c_ol), 32'd0);
    check("rst_ready", 32'(a_ir), 32'd1);

    // basic 8->16 word
    send_a(8'hA1, 1'b0);
    check("t1_mid_valid", 32'(a_ov), 32'd0);
    send_a(8'hB2, 1'b0);
    check("t1_valid", 32'(a_ov), 32'd1);
    check("t1_data",  32'(a_od), 32'h0000A1B2);
    check("t1_keep",  32'(a_ok), 32'h3);
    check("t1_last",  32'(a_ol), 32'd0);
    @(posedge clk); #1;
    check("t1_pulse", 32'(a_ov), 32'd0);

    // early close with in_last, then a fresh full word
    send_b(8'h11, 1'b0);
    send_b(8'h22, 1'b0);
    send_b(8'h33, 1'b1);
    check("t2_valid", 32'(b_ov), 32'd1);
    check("t2_data",  b_od, 32'h11223300);
    check("t2_keep",  32'(b_ok), 32'hE);
    check("t2_last",  32'(b_ol), 32'd1);
    send_b(8'h44, 1'b0);
    send_b(8'h55, 1'b0);
    send_b(8'h66, 1'b0);
    check("t2_fresh_wait", 32'(b_ov), 32'd0);
    send_b(8'h77, 1'b0);
    check("t2_fresh_data", b_od, 32'h44556677);
    check("t2_fresh_keep", 32'(b_ok), 32'hF);
    check("t2_fresh_last", 32'(b_ol), 32'd0);

    // LSB-first lane order
    send_c(8'h11, 1'b0);
    send_c(8'h22, 1'b0);
    send_c(8'h33, 1'b0);
    send_c(8'h44, 1'b0);
    check("t3_valid", 32'(c_ov), 32'd1);
    check("t3_data",  c_od, 32'h44332211);
    check("t3_keep",  32'(c_ok), 32'hF);

    // backpressure: word held, pending beat C3 must wait
    a_or = 1'b0;
    send_a(8'hA1, 1'b0);
    send_a(8'hB2, 1'b0);
    a_iv = 1'b1; a_id = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(a_ov), 32'd1);
      check("t4_hold_data",  32'(a_od), 32'h0000A1B2);
      check("t4_hold_ready", 32'(a_ir), 32'd0);
      @(posedge clk); #1;
    end
    a_or = 1'b1;
    @(posedge clk); #1;
    check("t4_drained", 32'(a_ov), 32'd0);
    a_id = 8'hD4;
    @(posedge clk); #1;
    a_iv = 1'b0;
    check("t4_next_valid", 32'(a_ov), 32'd1);
    check("t4_next_data",  32'(a_od), 32'h0000C3D4);

    // reset mid-word discards the partial word
    send_b(8'h11, 1'b0);
    send_b(8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_after_rst", 32'(b_ov), 32'd0);
    send_b(8'h55, 1'b0);
    send_b(8'h66, 1'b0);
    send_b(8'h77, 1'b0);
    check("t5_no_early", 32'(b_ov), 32'd0);
    send_b(8'h88, 1'b0);
    check("t5_valid", 32'(b_ov), 32'd1);
    check("t5_data",  b_od, 32'h55667788);

    // streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1'b1; a_id = 8'(i);
      @(posedge clk); #1;
      check("t6_ready", 32'(a_ir), 32'd1);
      if (i % 2 == 0) begin
        check("t6_valid", 32'(a_ov), 32'd1);
        check("t6_data",  32'(a_od), {16'h0, 8'(i - 1), 8'(i)});
      end else begin
        check("t6_gap", 32'(a_ov), 32'd0);
      end
    end
    a_iv = 1'b0;
    @(posedge clk); #1;
    check("t6_word_count", 32'(a_words), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
